mc_control_unit: RTL and testbench

- Multi-cycle successor to the single-cycle R-type control unit.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables for that step.
- Handshakes with instruction/data memory through a req/ready pair, with an optional timeout.
- Sits between the instruction register and the shared multi-cycle datapath: register file, ALU and memory port.

---
 rtl/mc_ctrl_pkg.sv | 35 +++
 rtl/alu_decoder.sv | 55 +++++
 rtl/mc_control_unit.sv | 202 ++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit:
// FSM states, opcodes, R-type functs and ALU operation codes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

endpackage

// File: rtl/alu_decoder.sv
// Combinational opcode/funct decode: ALU operation, shamt select
// and a flag marking the instruction as one the unit can execute.
module alu_decoder
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  shift,
    output logic                  valid
);

    logic [3:0] code;

    always_comb begin
        code  = ALU_AND;
        shift = 1'b0;
        valid = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                valid = 1'b1;
                unique case (funct)
                    FN_ADD: code = ALU_ADD;
                    FN_SUB: code = ALU_SUB;
                    FN_AND: code = ALU_AND;
                    FN_OR:  code = ALU_OR;
                    FN_SLL: begin
                        code  = ALU_SLL;
                        shift = 1'b1;
                    end
                    FN_SRL: begin
                        code  = ALU_SRL;
                        shift = 1'b1;
                    end
                    default: valid = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                code  = ALU_ADD;
                valid = 1'b1;
            end
            OP_BEQ: begin
                code  = ALU_SUB;
                valid = 1'b1;
            end
            OP_J:    valid = 1'b1;
            default: valid = 1'b0;
        endcase
    end

    assign alu_control = ALU_CTRL_W'(code);

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit with registered outputs.
// Define MC_CONTROL_PERF_COUNTERS_EN to add cycle/retired counters.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W  = 4,
    parameter int MEM_TIMEOUT = 0,
    parameter int COUNT_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  branch,
    output logic                  reg_write,
    output logic                  reg_dst,
    output logic                  alu_src_b,
    output logic                  mem_to_reg,
    output logic                  shift,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  instruction_class,
    output logic                  illegal,
    output logic                  bus_error
`ifdef MC_CONTROL_PERF_COUNTERS_EN
    ,
    output logic [COUNT_W-1:0]    cycle_count,
    output logic [COUNT_W-1:0]    retired_count
`endif
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    if (ALU_CTRL_W < 4) begin : g_bad_alu_w
        $error("ALU_CTRL_W must be at least 4");
    end
    if (COUNT_W < 1) begin : g_bad_count_w
        $error("COUNT_W must be at least 1");
    end

    state_t                state;
    logic [5:0]            op_q;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [ALU_CTRL_W-1:0] dec_alu;
    logic                  dec_shift;
    logic                  dec_valid;
    logic                  timeout_hit;

    alu_decoder #(
        .ALU_CTRL_W (ALU_CTRL_W)
    ) u_alu_decoder (
        .opcode      (opcode),
        .funct       (funct),
        .alu_control (dec_alu),
        .shift       (dec_shift),
        .valid       (dec_valid)
    );

    // mem_ready is checked first, so it wins over a same-cycle expiry
    assign timeout_hit = (MEM_TIMEOUT > 0) && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= FETCH;
            op_q              <= '0;
            wait_cnt          <= '0;
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            ir_write          <= 1'b0;
            pc_write          <= 1'b0;
            branch            <= 1'b0;
            reg_write         <= 1'b0;
            reg_dst           <= 1'b0;
            alu_src_b         <= 1'b0;
            mem_to_reg        <= 1'b0;
            shift             <= 1'b0;
            alu_control       <= '0;
            instruction_class <= 1'b0;
            illegal           <= 1'b0;
            bus_error         <= 1'b0;
        end else begin
            ir_write  <= 1'b0;
            pc_write  <= 1'b0;
            branch    <= 1'b0;
            reg_write <= 1'b0;
            unique case (state)
                FETCH: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        wait_cnt <= '0;
                    end else if (mem_ready) begin
                        mem_req  <= 1'b0;
                        ir_write <= 1'b1;
                        pc_write <= 1'b1;
                        state    <= DECODE;
                    end else if (timeout_hit) begin
                        mem_req   <= 1'b0;
                        bus_error <= 1'b1;
                        state     <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                DECODE: begin
                    op_q              <= opcode;
                    instruction_class <= (opcode != OP_RTYPE);
                    if (!dec_valid) begin
                        illegal <= 1'b1;
                        state   <= HALT;
                    end else if (opcode == OP_J) begin
                        pc_write <= 1'b1;
                        mem_req  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= FETCH;
                    end else begin
                        alu_control <= dec_alu;
                        shift       <= dec_shift;
                        alu_src_b   <= (opcode != OP_RTYPE) && (opcode != OP_BEQ);
                        branch      <= (opcode == OP_BEQ);
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    alu_control <= '0;
                    shift       <= 1'b0;
                    alu_src_b   <= 1'b0;
                    wait_cnt    <= '0;
                    if (op_q == OP_BEQ) begin
                        mem_req <= 1'b1;
                        state   <= FETCH;
                    end else if (op_q == OP_LW || op_q == OP_SW) begin
                        mem_req <= 1'b1;
                        mem_we  <= (op_q == OP_SW);
                        state   <= MEM;
                    end else begin
                        reg_write <= 1'b1;
                        reg_dst   <= (op_q == OP_RTYPE);
                        state     <= WB;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        mem_we   <= 1'b0;
                        wait_cnt <= '0;
                        if (op_q == OP_SW) begin
                            state <= FETCH;
                        end else begin
                            mem_req    <= 1'b0;
                            reg_write  <= 1'b1;
                            mem_to_reg <= 1'b1;
                            state      <= WB;
                        end
                    end else if (timeout_hit) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        bus_error <= 1'b1;
                        state     <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                WB: begin
                    reg_dst    <= 1'b0;
                    mem_to_reg <= 1'b0;
                    mem_req    <= 1'b1;
                    wait_cnt   <= '0;
                    state      <= FETCH;
                end
                HALT: state <= HALT;
                default: state <= HALT;
            endcase
        end
    end

`ifdef MC_CONTROL_PERF_COUNTERS_EN
    logic retire;

    assign retire = (state == WB)
                  || (state == EXEC && op_q == OP_BEQ)
                  || (state == MEM && op_q == OP_SW && mem_ready)
                  || (state == DECODE && dec_valid && opcode == OP_J);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count   <= '0;
            retired_count <= '0;
        end else begin
            if (state != HALT)
                cycle_count <= cycle_count + COUNT_W'(1);
            if (retire)
                retired_count <= retired_count + COUNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: per-instruction vector table plus
// hand sequences for memory waits, HALT, timeout and mid-access reset.
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = 6'b0;
    logic [5:0] funct = 6'b0;
    logic       mem_ready = 1'b0;

    logic       mem_req, mem_we, ir_write, pc_write, branch, reg_write;
    logic       reg_dst, alu_src_b, mem_to_reg, shift;
    logic [3:0] alu_control;
    logic       instruction_class, illegal, bus_error;

    logic       t_mem_req, t_mem_we, t_ir_write, t_pc_write, t_branch;
    logic       t_reg_write, t_reg_dst, t_alu_src_b, t_mem_to_reg, t_shift;
    logic [3:0] t_alu_control;
    logic       t_instruction_class, t_illegal, t_bus_error;

`ifdef MC_CONTROL_PERF_COUNTERS_EN
    logic [31:0] cycle_count, retired_count;
    logic [31:0] t_cycle_count, t_retired_count;
    int          cyc;
    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mc_control_unit u_dut (
        .clk (clk), .rst (rst), .opcode (opcode), .funct (funct),
        .mem_ready (mem_ready), .mem_req (mem_req), .mem_we (mem_we),
        .ir_write (ir_write), .pc_write (pc_write), .branch (branch),
        .reg_write (reg_write), .reg_dst (reg_dst),
        .alu_src_b (alu_src_b), .mem_to_reg (mem_to_reg),
        .shift (shift), .alu_control (alu_control),
        .instruction_class (instruction_class),
        .illegal (illegal), .bus_error (bus_error)
`ifdef MC_CONTROL_PERF_COUNTERS_EN
        , .cycle_count (cycle_count), .retired_count (retired_count)
`endif
    );

    mc_control_unit #(.MEM_TIMEOUT (8)) u_tmo (
        .clk (clk), .rst (rst), .opcode (opcode), .funct (funct),
        .mem_ready (mem_ready), .mem_req (t_mem_req), .mem_we (t_mem_we),
        .ir_write (t_ir_write), .pc_write (t_pc_write), .branch (t_branch),
        .reg_write (t_reg_write), .reg_dst (t_reg_dst),
        .alu_src_b (t_alu_src_b), .mem_to_reg (t_mem_to_reg),
        .shift (t_shift), .alu_control (t_alu_control),
        .instruction_class (t_instruction_class),
        .illegal (t_illegal), .bus_error (t_bus_error)
`ifdef MC_CONTROL_PERF_COUNTERS_EN
        , .cycle_count (t_cycle_count), .retired_count (t_retired_count)
`endif
    );

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        int         lat;
        logic [3:0] alu;
        logic       sh, sb, br;
        int         nwr;
        logic       dst, m2r, we, cls;
    } vec_t;

    typedef struct {
        int         lat;
        logic [3:0] alu;
        logic       sh, sb, br;
        int         nwr;
        logic       dst, m2r, we, cls;
    } obs_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        opcode = 6'b0;
        funct = 6'b100000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Leaves the bench at the negedge of a DECODE cycle (ir_write high).
    task automatic wait_decode();
        bit seen = 0;
        mem_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ir_write) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("wait_decode_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_one(input logic [5:0] op, input logic [5:0] fn,
                           output obs_t o);
        o.lat = 0; o.alu = '0; o.sh = 0; o.sb = 0; o.br = 0;
        o.nwr = 0; o.dst = 0; o.m2r = 0; o.we = 0; o.cls = 0;
        opcode = op;
        funct  = fn;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                o.alu = alu_control; o.sh = shift; o.sb = alu_src_b;
                o.br = branch; o.cls = instruction_class;
            end
            if (reg_write) begin
                o.nwr++;
                o.dst = reg_dst;
                o.m2r = mem_to_reg;
            end
            if (mem_we) o.we = 1'b1;
            if (ir_write) begin
                o.lat = k;
                break;
            end
        end
    endtask

    initial begin : main
        obs_t o;
        int   cnt;
        int   bad;
        bit   seen;

        tbl[0]  = '{"add",  6'b000000, 6'b100000, 4, 4'b0010, 0, 0, 0, 1, 1, 0, 0, 0};
        tbl[1]  = '{"sub",  6'b000000, 6'b100010, 4, 4'b0100, 0, 0, 0, 1, 1, 0, 0, 0};
        tbl[2]  = '{"and",  6'b000000, 6'b100100, 4, 4'b0000, 0, 0, 0, 1, 1, 0, 0, 0};
        tbl[3]  = '{"or",   6'b000000, 6'b100101, 4, 4'b0001, 0, 0, 0, 1, 1, 0, 0, 0};
        tbl[4]  = '{"srl",  6'b000000, 6'b000010, 4, 4'b1001, 1, 0, 0, 1, 1, 0, 0, 0};
        tbl[5]  = '{"sll",  6'b000000, 6'b000000, 4, 4'b1000, 1, 0, 0, 1, 1, 0, 0, 0};
        tbl[6]  = '{"beq",  6'b000100, 6'b100000, 3, 4'b0100, 0, 0, 1, 0, 0, 0, 0, 1};
        tbl[7]  = '{"addi", 6'b001000, 6'b101010, 4, 4'b0010, 0, 1, 0, 1, 0, 0, 0, 1};
        tbl[8]  = '{"lw",   6'b100011, 6'b000000, 5, 4'b0010, 0, 1, 0, 1, 0, 1, 0, 1};
        tbl[9]  = '{"sw",   6'b101011, 6'b000000, 4, 4'b0010, 0, 1, 0, 0, 0, 0, 1, 1};
        tbl[10] = '{"j",    6'b000010, 6'b000000, 2, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1};

        // reset values and first mem_req
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {18'b0, mem_req, mem_we, ir_write, pc_write, branch, reg_write,
               reg_dst, alu_src_b, mem_to_reg, shift, alu_control,
               instruction_class, illegal, bus_error},
              32'd0);
        rst = 1'b0;
        #1 check("mem_req_before_edge", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        check("mem_req_first_edge", {31'b0, mem_req}, 32'd1);

        // table of single instructions, zero-wait memory
        do_reset();
        wait_decode();
        foreach (tbl[i]) begin
            run_one(tbl[i].op, tbl[i].fn, o);
            check({tbl[i].name, "_latency"}, 32'(o.lat), 32'(tbl[i].lat));
            check({tbl[i].name, "_signals"},
                  {20'b0, o.alu, o.sh, o.sb, o.br, 2'(o.nwr), o.dst, o.m2r, o.we, o.cls},
                  {20'b0, tbl[i].alu, tbl[i].sh, tbl[i].sb, tbl[i].br,
                   2'(tbl[i].nwr), tbl[i].dst, tbl[i].m2r, tbl[i].we, tbl[i].cls});
        end
        check("no_flags_after_table", {30'b0, illegal, bus_error}, 32'd0);

        // lw with data memory 3 wait cycles
        do_reset();
        wait_decode();
        opcode = 6'b100011;
        mem_ready = 1'b0;
        cnt = 0;
        seen = 0;
        o.lat = 0;
        o.m2r = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ir_write) begin
                o.lat = k;
                break;
            end
            if (reg_write) begin
                seen = 1;
                o.m2r = mem_to_reg;
            end
            if (mem_req && !seen) begin
                cnt++;
                if (cnt == 4) mem_ready = 1'b1;
            end
        end
        check("lw_wait_mem_req_cycles", 32'(cnt), 32'd4);
        check("lw_wait_mem_to_reg", {31'b0, o.m2r}, 32'd1);
        check("lw_wait_latency", 32'(o.lat), 32'd8);

        // undecodable R-type funct parks in HALT
        do_reset();
        wait_decode();
        opcode = 6'b000000;
        funct = 6'b101010;
        @(negedge clk);
        check("illegal_funct_flag", {31'b0, illegal}, 32'd1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!illegal || mem_req || ir_write) bad++;
        end
        check("illegal_held_20", 32'(bad), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("illegal_cleared_by_rst", {31'b0, illegal}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        check("mem_req_restart", {31'b0, mem_req}, 32'd1);

        // unknown opcode
        do_reset();
        wait_decode();
        opcode = 6'b111111;
        @(negedge clk);
        check("illegal_opcode_flag", {30'b0, illegal, mem_req}, 32'd2);

        // timeout: mem_ready never comes
        do_reset();
        cnt = 0;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (t_bus_error) begin
                seen = 1;
                break;
            end
            if (t_mem_req) cnt++;
        end
        check("timeout_seen", {31'b0, seen}, 32'd1);
        check("timeout_req_cycles", 32'(cnt), 32'd8);
        check("timeout_req_dropped", {31'b0, t_mem_req}, 32'd0);
        check("no_timeout_when_disabled", {30'b0, bus_error, mem_req}, 32'd1);

        // timeout: mem_ready on the 8th cycle wins
        do_reset();
        cnt = 0;
        for (int k = 0; k < 30 && cnt < 8; k++) begin
            @(negedge clk);
            if (t_mem_req) cnt++;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        check("ready_at_limit", {30'b0, t_bus_error, t_ir_write}, 32'd1);

        // reset during sw MEM wait
        do_reset();
        wait_decode();
        opcode = 6'b101011;
        mem_ready = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_we) begin
                seen = 1;
                break;
            end
        end
        check("sw_reached_mem", {30'b0, seen, mem_req}, 32'd3);
        #2 rst = 1'b1;
        #1 check("rst_drops_mem_req_we", {30'b0, mem_req, mem_we}, 32'd0);
        bad = 0;
        repeat (2) begin
            @(negedge clk);
            if (reg_write) bad++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (reg_write) bad++;
        end
        check("no_write_after_abort", 32'(bad), 32'd0);

`ifdef MC_CONTROL_PERF_COUNTERS_EN
        do_reset();
        wait_decode();
        run_one(6'b000000, 6'b100000, o);
        run_one(6'b001000, 6'b000000, o);
        run_one(6'b000010, 6'b000000, o);
        check("retired_after_3", retired_count, 32'd3);
        check("cycle_count", cycle_count, 32'(cyc));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
